if_id_skid_reg: RTL
===================

Name: if_id_skid_reg

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries a PC plus a payload word between two pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so in_ready is registered and the combinational out_ready→in_ready path is cut.
- Keeps the existing freeze/flush semantics, inserts a NOP value on bubbles, and provides a saturating stall counter for performance monitoring.

Parameters:
- PC_W, 32, width of the PC field.
- DATA_W, 32, width of the payload (instruction) field.
- NOP_VALUE, 0, value driven on out_data whenever out_valid is 0.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all held entries and the current input.
- freeze  in  1  hold all state; no transfers on either side.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid, masked by freeze.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  head PC; 0 when no entry is held.
- out_data  out  DATA_W  head payload; NOP_VALUE when no entry is held.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage: a main entry (head) and a skid entry. State is one of EMPTY, ONE or TWO; encode as a 2-bit register or as two valid bits.
- Control signals:
  - push = in_valid & in_ready & !freeze & !flush.
  - pop = out_valid & out_ready. out_valid already includes !freeze.
  - in_ready = (state != TWO) & !freeze. It depends only on registers and freeze, never on out_ready or in_valid.
  - out_valid = (state != EMPTY) & !freeze.
- Priority per clock edge: rst > flush > freeze > handshake.
- rst: state←EMPTY, both entries←0, stall_count←0. Outputs after reset:
  - in_ready=1, out_valid=0, out_pc=0, out_data=NOP_VALUE.
- flush: state←EMPTY and both entries←0, regardless of freeze or in_valid. The input presented in the flush cycle is dropped. Any pop that completes in the flush cycle is still considered delivered. stall_count is not cleared.
- freeze (without flush): state and entries hold and stall_count updates per its rule. in_ready and out_valid both read 0 combinationally in that cycle.
- Transitions (no rst/flush/freeze):
  - EMPTY: push → ONE (main←input).
  - ONE, push & pop → ONE (main←input).
  - ONE, push & !pop → TWO (skid←input).
  - ONE, !push & pop → EMPTY (main←0).
  - TWO, pop → ONE (main←skid, skid←0).
  - TWO: push is impossible because in_ready=0.
- Latency and throughput:
  - An input accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY, or when it was ONE and popping.
  - Sustained throughput is 1 entry/cycle with out_ready held high.
  - Order is strictly FIFO: the skid entry is never presented before main.
- Data outputs are driven from main only. When state=EMPTY: out_pc=0, out_data=NOP_VALUE.
- stall_count increments by 1 on an edge where state!=EMPTY, no rst, no flush, and no pop (backpressure or freeze). It saturates at 2^CNT_W−1 and never wraps. It is cleared only by rst.
- Reset mid-operation overrides everything; no entry survives.

Decomposition:
- Shared package holds the state encoding localparams (ST_EMPTY=0, ST_ONE=1, ST_TWO=2), with NOP_VALUE defaulted from the package's ARM NOP constant.
- Natural sub-module: sat_counter (parametrised width; ports inc, clr, count). It is reusable for other pipeline-stage statistics.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, out_pc=0, out_data=NOP_VALUE, stall_count=0.
- Streaming: push PC 0x00, 0x04, 0x08 with out_ready=1 → each appears exactly one cycle later, in order, state never reaches TWO.
- Backpressure: out_ready=0 while pushing 0x10, then 0x14 → state TWO, in_ready=0 on the next cycle, out_pc holds 0x10. Raise out_ready → 0x10 then 0x14 are delivered; stall_count increases by the number of held cycles.
- Freeze for 3 cycles with one entry held (PC 0x20) → in_ready=0, out_valid=0, out_pc=0x20 held, stall_count +3. Release → 0x20 is popped.
- Flush in state TWO together with freeze=1 and in_valid=1 (PC 0x30) → next cycle EMPTY, out_pc=0, out_data=NOP_VALUE, 0x30 never appears.
- Saturation: CNT_W=4, hold backpressure for 20 cycles → stall_count stops at 15. rst → 0.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the fetch/decode skid register and its helpers.
package if_id_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // A32 "andeq r0, r0, r0": the all-zero word executes as a NOP.
  localparam logic [31:0] ARM_NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// Fetch/decode pipeline register with a 2-entry skid buffer, registered in_ready,
// freeze/flush control, NOP insertion on bubbles and a saturating stall counter.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    NOP_VALUE = DATA_W'(ARM_NOP),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                push, pop, stall_inc;

  // in_ready is a function of registered state and freeze only, so no
  // combinational path runs from out_ready back to the upstream stage.
  assign in_ready  = (state_q != ST_TWO) && !freeze;
  assign out_valid = (state_q != ST_EMPTY) && !freeze;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_pc_d   = '0;
      main_data_d = '0;
      skid_pc_d   = '0;
      skid_data_d = '0;
    end else if (!freeze) begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end else if (push) begin
            state_d     = ST_TWO;
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_pc_d   = '0;
            main_data_d = '0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            skid_pc_d   = '0;
            skid_data_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_pc   = (state_q == ST_EMPTY) ? '0 : main_pc_q;
  assign out_data = (state_q == ST_EMPTY) ? NOP_VALUE : main_data_q;

  assign stall_inc = (state_q != ST_EMPTY) && !flush && !pop;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

endmodule
